// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: N-approach traffic light sequencer.
//
// Cycles ALLRED -> GREEN -> YELLOW -> ALLRED, choosing the next approach by
// preferential request first and round-robin otherwise. Supports a one-shot
// green extension, per-approach hold-red and a flashing-yellow attention mode.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   attention   request flashing-yellow on all approaches
//   preset_add  level request to extend the current green once
//   force_red   bit i holds approach i red and removes it from selection
//   pref        bit i is a preferential request for approach i
//   ltf         lamp triple per approach: 100 red, 010 yellow, 001 green, 000 dark
//   active_idx  approach owning green/yellow
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_DARK   | in reset or first cycle after it, all lamps off
// S_ALLRED | clearance interval, next approach picked at its end
// S_GREEN  | active approach green, may be extended once
// S_YELLOW | active approach yellow
// S_FLASH  | all approaches flash yellow while attention is high

module traffic_ctrl_n #(
    parameter int N_WAY      = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 2,
    parameter int EXT_CYC    = 4,
    parameter int FLASH_CYC  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       attention,
    input  logic                       preset_add,
    input  logic [N_WAY-1:0]           force_red,
    input  logic [N_WAY-1:0]           pref,
    output logic [N_WAY-1:0][2:0]      ltf,
    output logic [$clog2(N_WAY)-1:0]   active_idx
);

    localparam int IDX_W  = $clog2(N_WAY);
    localparam int IDXW1  = IDX_W + 1;
    localparam int CNT_W  = $clog2(GREEN_CYC + EXT_CYC + 1);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_CYC - 1);
    localparam logic [CNT_W-1:0] EXT_ADD   = CNT_W'(EXT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    typedef enum logic [2:0] {
        S_DARK,
        S_ALLRED,
        S_GREEN,
        S_YELLOW,
        S_FLASH
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               ext_used, ext_nxt;
    logic               flash_phase, phase_nxt;
    logic [N_WAY-1:0][2:0] ltf_nxt;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W:0]     cand_w;

    // Next-approach selection. Loops run from lowest to highest priority so
    // the last hit wins: highest index first for pref, farthest-first for
    // round-robin (k = N_WAY revisits the current approach as a last resort).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_w    = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (pref[i] && !force_red[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        if (!sel_found) begin
            for (int k = N_WAY; k >= 1; k--) begin
                cand_w = {1'b0, active_idx} + IDXW1'(k);
                if (cand_w >= IDXW1'(N_WAY)) begin
                    cand_w = cand_w - IDXW1'(N_WAY);
                end
                if (!force_red[cand_w[IDX_W-1:0]]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand_w[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = active_idx;
        ext_nxt   = ext_used;
        phase_nxt = flash_phase;

        case (state)
            S_DARK: begin
                state_nxt = S_ALLRED;
                cnt_nxt   = ALLRED_LD;
            end
            S_FLASH: begin
                if (!attention) begin
                    state_nxt = S_ALLRED;
                    cnt_nxt   = ALLRED_LD;
                end else if (cnt == '0) begin
                    phase_nxt = ~flash_phase;
                    cnt_nxt   = FLASH_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                if (attention) begin
                    state_nxt = S_FLASH;
                    cnt_nxt   = FLASH_LD;
                    phase_nxt = 1'b0;
                end else begin
                    case (state)
                        S_ALLRED: begin
                            if (cnt != '0) begin
                                cnt_nxt = cnt - CNT_ONE;
                            end else if (sel_found) begin
                                state_nxt = S_GREEN;
                                idx_nxt   = sel_idx;
                                cnt_nxt   = GREEN_LD;
                                ext_nxt   = 1'b0;
                            end
                            // nothing selectable: hold at zero and retry
                        end
                        S_GREEN: begin
                            if (force_red[active_idx] || cnt == '0) begin
                                state_nxt = S_YELLOW;
                                cnt_nxt   = YELLOW_LD;
                            end else if (preset_add && !ext_used) begin
                                cnt_nxt = cnt - CNT_ONE + EXT_ADD;
                                ext_nxt = 1'b1;
                            end else begin
                                cnt_nxt = cnt - CNT_ONE;
                            end
                        end
                        S_YELLOW: begin
                            if (cnt == '0) begin
                                state_nxt = S_ALLRED;
                                cnt_nxt   = ALLRED_LD;
                            end else begin
                                cnt_nxt = cnt - CNT_ONE;
                            end
                        end
                        default: begin
                            state_nxt = S_DARK;
                            cnt_nxt   = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    // Lamps are computed from the next state so the registered ltf lines up
    // with the state register.
    always_comb begin
        ltf_nxt = '0;
        for (int i = 0; i < N_WAY; i++) begin
            case (state_nxt)
                S_ALLRED: ltf_nxt[i] = LAMP_RED;
                S_GREEN:  ltf_nxt[i] = (IDX_W'(i) == idx_nxt) ? LAMP_GREEN : LAMP_RED;
                S_YELLOW: ltf_nxt[i] = (IDX_W'(i) == idx_nxt) ? LAMP_YELLOW : LAMP_RED;
                S_FLASH:  ltf_nxt[i] = phase_nxt ? LAMP_OFF : LAMP_YELLOW;
                default:  ltf_nxt[i] = LAMP_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_DARK;
            cnt         <= '0;
            active_idx  <= IDX_W'(N_WAY - 1);
            ext_used    <= 1'b0;
            flash_phase <= 1'b0;
            ltf         <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            active_idx  <= idx_nxt;
            ext_used    <= ext_nxt;
            flash_phase <= phase_nxt;
            ltf         <= ltf_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Testbench for traffic_ctrl_n: directed scenarios plus a randomized run
// compared against a phase/elapsed-time reference model.

module tb_traffic_ctrl_n;

    localparam int N_WAY      = 4;
    localparam int GREEN_CYC  = 8;
    localparam int YELLOW_CYC = 2;
    localparam int ALLRED_CYC = 2;
    localparam int EXT_CYC    = 4;
    localparam int FLASH_CYC  = 3;
    localparam int IDX_W      = $clog2(N_WAY);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  attention = 1'b0;
    logic                  preset_add = 1'b0;
    logic [N_WAY-1:0]      force_red = '0;
    logic [N_WAY-1:0]      pref = '0;
    logic [N_WAY-1:0][2:0] ltf;
    logic [IDX_W-1:0]      active_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_ctrl_n #(
        .N_WAY(N_WAY), .GREEN_CYC(GREEN_CYC), .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC), .EXT_CYC(EXT_CYC), .FLASH_CYC(FLASH_CYC)
    ) dut (
        .clk(clk), .rst(rst), .attention(attention), .preset_add(preset_add),
        .force_red(force_red), .pref(pref), .ltf(ltf), .active_idx(active_idx)
    );

    function automatic logic [N_WAY*3-1:0] pattern(int idx, logic [2:0] on_code, logic [2:0] rest_code);
        logic [N_WAY*3-1:0] v;
        for (int i = 0; i < N_WAY; i++) v[i*3 +: 3] = (i == idx) ? on_code : rest_code;
        return v;
    endfunction

    // Reference model: mode, cycles spent in it, and its planned duration.
    localparam int M_DARK = 0, M_ALLRED = 1, M_GREEN = 2, M_YELLOW = 3, M_FLASH = 4;
    int m_mode = M_DARK;
    int m_age  = 0;
    int m_dur  = 0;
    int m_idx  = N_WAY - 1;
    bit m_ext  = 0;

    function automatic int model_pick(int cur, logic [N_WAY-1:0] fr, logic [N_WAY-1:0] pf);
        for (int i = 0; i < N_WAY; i++) if (pf[i] && !fr[i]) return i;
        for (int k = 1; k <= N_WAY; k++) if (!fr[(cur + k) % N_WAY]) return (cur + k) % N_WAY;
        return -1;
    endfunction

    always @(posedge clk) begin
        int p;
        if (!rst) begin
            m_mode = M_DARK; m_idx = N_WAY - 1; m_ext = 0; m_age = 0; m_dur = 0;
        end else if (m_mode == M_DARK) begin
            m_mode = M_ALLRED; m_dur = ALLRED_CYC; m_age = 1;
        end else if (m_mode == M_FLASH) begin
            if (!attention) begin m_mode = M_ALLRED; m_dur = ALLRED_CYC; m_age = 1; end
            else m_age++;
        end else if (attention) begin
            m_mode = M_FLASH; m_age = 1;
        end else if (m_mode == M_ALLRED) begin
            if (m_age < m_dur) m_age++;
            else begin
                p = model_pick(m_idx, force_red, pref);
                if (p >= 0) begin
                    m_idx = p; m_mode = M_GREEN; m_dur = GREEN_CYC; m_age = 1; m_ext = 0;
                end
            end
        end else if (m_mode == M_GREEN) begin
            if (force_red[m_idx] || m_age >= m_dur) begin
                m_mode = M_YELLOW; m_dur = YELLOW_CYC; m_age = 1;
            end else begin
                if (preset_add && !m_ext) begin m_dur += EXT_CYC; m_ext = 1; end
                m_age++;
            end
        end else begin
            if (m_age >= m_dur) begin m_mode = M_ALLRED; m_dur = ALLRED_CYC; m_age = 1; end
            else m_age++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; attention = 1'b0; preset_add = 1'b0; force_red = '0; pref = '0;
        cyc(2);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ltf !== pattern(0, OFF, OFF)) begin
            errors++; $display("FAIL reset_ltf: got %b want %b", ltf, pattern(0, OFF, OFF));
        end
        checks++;
        if (active_idx !== IDX_W'(N_WAY - 1)) begin
            errors++; $display("FAIL reset_idx: got %0d want %0d", active_idx, N_WAY - 1);
        end
    endtask

    task automatic test_basic_cycle();
        logic [N_WAY*3-1:0] exp;
        apply_reset();
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            cyc(1);
            if (c < 2)       exp = pattern(0, RED, RED);
            else if (c < 10) exp = pattern(0, GRN, RED);
            else if (c < 12) exp = pattern(0, YEL, RED);
            else if (c < 14) exp = pattern(0, RED, RED);
            else             exp = pattern(1, GRN, RED);
            checks++;
            if (ltf !== exp) begin
                errors++; $display("FAIL basic_cycle c=%0d: got %b want %b", c, ltf, exp);
            end
        end
        checks++;
        if (active_idx !== IDX_W'(1)) begin
            errors++; $display("FAIL basic_idx: got %0d want 1", active_idx);
        end
    endtask

    task automatic test_preset();
        int n;
        apply_reset();
        rst = 1'b1;
        cyc(3);
        n = 0;
        while (ltf === pattern(0, GRN, RED) && n < 40) begin
            preset_add = (n == 2 || n == 5);
            cyc(1);
            n++;
        end
        preset_add = 1'b0;
        checks++;
        if (n != GREEN_CYC + EXT_CYC) begin
            errors++; $display("FAIL preset_green_len: got %0d want %0d", n, GREEN_CYC + EXT_CYC);
        end
        checks++;
        if (ltf !== pattern(0, YEL, RED)) begin
            errors++; $display("FAIL preset_then_yellow: got %b want %b", ltf, pattern(0, YEL, RED));
        end
    endtask

    task automatic test_pref();
        apply_reset();
        rst = 1'b1;
        cyc(3);
        pref = 4'b0100;
        cyc(12);
        checks++;
        if (ltf !== pattern(2, GRN, RED) || active_idx !== IDX_W'(2)) begin
            errors++; $display("FAIL pref_pick: got %b idx %0d want %b idx 2", ltf, active_idx, pattern(2, GRN, RED));
        end
        apply_reset();
        rst = 1'b1;
        cyc(3);
        force_red = 4'b0010;
        cyc(12);
        checks++;
        if (ltf !== pattern(2, GRN, RED) || active_idx !== IDX_W'(2)) begin
            errors++; $display("FAIL rr_skip_forced: got %b idx %0d want %b idx 2", ltf, active_idx, pattern(2, GRN, RED));
        end
    endtask

    task automatic test_force();
        logic [N_WAY*3-1:0] exp;
        apply_reset();
        rst = 1'b1;
        cyc(5);
        force_red = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            if (c < 2)      exp = pattern(0, YEL, RED);
            else if (c < 4) exp = pattern(0, RED, RED);
            else            exp = pattern(1, GRN, RED);
            checks++;
            if (ltf !== exp) begin
                errors++; $display("FAIL force_cut c=%0d: got %b want %b", c, ltf, exp);
            end
        end
        force_red = 4'b1111;
        cyc(1);
        checks++;
        if (ltf !== pattern(1, YEL, RED)) begin
            errors++; $display("FAIL force_all_yellow: got %b want %b", ltf, pattern(1, YEL, RED));
        end
        cyc(3);
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            checks++;
            if (ltf !== pattern(0, RED, RED) || active_idx !== IDX_W'(1)) begin
                errors++; $display("FAIL force_all_red c=%0d: got %b idx %0d", c, ltf, active_idx);
            end
        end
    endtask

    task automatic test_attention();
        logic [N_WAY*3-1:0] exp;
        apply_reset();
        rst = 1'b1;
        cyc(5);
        attention = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc(1);
            exp = ((c / FLASH_CYC) % 2 == 0) ? pattern(0, YEL, YEL) : pattern(0, OFF, OFF);
            checks++;
            if (ltf !== exp) begin
                errors++; $display("FAIL flash c=%0d: got %b want %b", c, ltf, exp);
            end
        end
        attention = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            exp = (c < 2) ? pattern(0, RED, RED) : pattern(1, GRN, RED);
            checks++;
            if (ltf !== exp) begin
                errors++; $display("FAIL flash_exit c=%0d: got %b want %b", c, ltf, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rst = 1'b1;
        cyc(11);
        checks++;
        if (ltf !== pattern(0, YEL, RED)) begin
            errors++; $display("FAIL mid_pre_yellow: got %b want %b", ltf, pattern(0, YEL, RED));
        end
        rst = 1'b0;
        cyc(1);
        checks++;
        if (ltf !== pattern(0, OFF, OFF) || active_idx !== IDX_W'(N_WAY - 1)) begin
            errors++; $display("FAIL mid_reset: got %b idx %0d want all 000 idx %0d", ltf, active_idx, N_WAY - 1);
        end
        rst = 1'b1;
        cyc(3);
        checks++;
        if (ltf !== pattern(0, GRN, RED) || active_idx !== IDX_W'(0)) begin
            errors++; $display("FAIL mid_restart: got %b idx %0d want %b idx 0", ltf, active_idx, pattern(0, GRN, RED));
        end
    endtask

    task automatic test_random();
        logic [N_WAY*3-1:0] exp;
        logic [2:0] lamp;
        apply_reset();
        rst = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 59) == 0) attention = ~attention;
            rst        = ($urandom_range(0, 199) != 0);
            preset_add = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) force_red = N_WAY'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 99) == 0) force_red = '1;
            if ($urandom_range(0, 9) == 0) pref = N_WAY'($urandom & $urandom & $urandom);
            cyc(1);
            for (int i = 0; i < N_WAY; i++) begin
                case (m_mode)
                    M_ALLRED: lamp = RED;
                    M_GREEN:  lamp = (i == m_idx) ? GRN : RED;
                    M_YELLOW: lamp = (i == m_idx) ? YEL : RED;
                    M_FLASH:  lamp = (((m_age - 1) / FLASH_CYC) % 2 == 0) ? YEL : OFF;
                    default:  lamp = OFF;
                endcase
                exp[i*3 +: 3] = lamp;
            end
            checks++;
            if (ltf !== exp) begin
                errors++; $display("FAIL random_ltf c=%0d: got %b want %b", c, ltf, exp);
            end
            checks++;
            if (active_idx !== IDX_W'(m_idx)) begin
                errors++; $display("FAIL random_idx c=%0d: got %0d want %0d", c, active_idx, m_idx);
            end
        end
        attention = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_cycle();
        test_preset();
        test_pref();
        test_force();
        test_attention();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
